// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and command-payload definitions for the ALU sequencer.
package alu_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned CMD_W  = 2 * OPND_W + OP_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NAND = 4'd7,
    OP_NOR  = 4'd8,
    OP_XNOR = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_MIN  = 4'd12,
    OP_MAX  = 4'd13,
    OP_LT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } cmd_t;

  localparam logic [RES_W-1:0] DIVZ_DATA = 8'hFF;

  // A divide with a zero divisor bypasses the external ALU result.
  function automatic logic is_divz(input logic [OP_W-1:0] op, input logic [OPND_W-1:0] b);
    return (op == OP_W'(OP_DIV)) && (b == '0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers, occupancy count and full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands, drives an external combinational ALU one command at a
// time and returns each registered result over a valid/ready response port.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [OPND_W-1:0] i_cmd_a,
  input  logic [OPND_W-1:0] i_cmd_b,
  input  logic [OP_W-1:0]   i_cmd_op,
  output logic [OPND_W-1:0] o_alu_in1,
  output logic [OPND_W-1:0] o_alu_in2,
  output logic [OP_W-1:0]   o_alu_op,
  input  logic [RES_W-1:0]  i_alu_result,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [RES_W-1:0]  o_rsp_data,
  output logic [OP_W-1:0]   o_rsp_op,
  output logic              o_rsp_divz,
  output logic              o_busy
);

  cmd_t   wr_cmd;
  cmd_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;

  state_e state;
  state_e state_d;

  logic [OPND_W-1:0] alu_in1_d;
  logic [OPND_W-1:0] alu_in2_d;
  logic [OP_W-1:0]   alu_op_d;
  logic              rsp_valid_d;
  logic [RES_W-1:0]  rsp_data_d;
  logic [OP_W-1:0]   rsp_op_d;
  logic              rsp_divz_d;

  assign wr_cmd = '{op: i_cmd_op, a: i_cmd_a, b: i_cmd_b};

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_cmd_valid),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_cmd_ready = !fifo_full;
  assign o_busy      = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state and next-output logic; every register holds unless a state updates it.
  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    alu_in1_d   = o_alu_in1;
    alu_in2_d   = o_alu_in2;
    alu_op_d    = o_alu_op;
    rsp_valid_d = o_rsp_valid;
    rsp_data_d  = o_rsp_data;
    rsp_op_d    = o_rsp_op;
    rsp_divz_d  = o_rsp_divz;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          alu_in1_d = head.a;
          alu_in2_d = head.b;
          alu_op_d  = head.op;
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        rsp_valid_d = 1'b1;
        rsp_op_d    = o_alu_op;
        if (is_divz(o_alu_op, o_alu_in2)) begin
          rsp_divz_d = 1'b1;
          rsp_data_d = DIVZ_DATA;
        end else begin
          rsp_divz_d = 1'b0;
          rsp_data_d = i_alu_result;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Chaining straight into DRIVE keeps throughput at one result per two cycles.
          if (!fifo_empty) begin
            pop       = 1'b1;
            alu_in1_d = head.a;
            alu_in2_d = head.b;
            alu_op_d  = head.op;
            state_d   = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_alu_in1   <= '0;
      o_alu_in2   <= '0;
      o_alu_op    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_op    <= '0;
      o_rsp_divz  <= 1'b0;
    end else begin
      o_alu_in1   <= alu_in1_d;
      o_alu_in2   <= alu_in2_d;
      o_alu_op    <= alu_op_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_data  <= rsp_data_d;
      o_rsp_op    <= rsp_op_d;
      o_rsp_divz  <= rsp_divz_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with an external reference ALU.
module tb_alu_sequencer;

  localparam int unsigned DEPTH = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [3:0] i_cmd_a;
  logic [3:0] i_cmd_b;
  logic [3:0] i_cmd_op;
  logic [3:0] o_alu_in1;
  logic [3:0] o_alu_in2;
  logic [3:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_data;
  logic [3:0] o_rsp_op;
  logic       o_rsp_divz;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [12:0] rsp_q[$];
  int          stamp_q[$];

  always #5 i_clk = ~i_clk;

  alu_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_a      (i_cmd_a),
    .i_cmd_b      (i_cmd_b),
    .i_cmd_op     (i_cmd_op),
    .o_alu_in1    (o_alu_in1),
    .o_alu_in2    (o_alu_in2),
    .o_alu_op     (o_alu_op),
    .i_alu_result (i_alu_result),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_op     (o_rsp_op),
    .o_rsp_divz   (o_rsp_divz),
    .o_busy       (o_busy)
  );

  // Reference ALU; a zero divisor yields 0 so a missing override is visible.
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
    case (op)
      4'd0:    return 8'(a) + 8'(b);
      4'd1:    return 8'(a) - 8'(b);
      4'd2:    return 8'(a) * 8'(b);
      4'd3:    return (b == 4'd0) ? 8'h00 : 8'(a / b);
      4'd4:    return 8'(a & b);
      4'd5:    return 8'(a | b);
      4'd6:    return 8'(a ^ b);
      4'd15:   return 8'(a == b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb i_alu_result = alu_model(o_alu_in1, o_alu_in2, o_alu_op);

  always @(posedge i_clk) cyc <= cyc + 1;

  // Responses are taken mid-cycle, where valid/ready already show the coming edge's handshake.
  always @(negedge i_clk) begin
    if (!i_rst && o_rsp_valid && i_rsp_ready) begin
      rsp_q.push_back({o_rsp_data, o_rsp_op, o_rsp_divz});
      stamp_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present a command and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    bit done = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_a     = a;
    i_cmd_b     = b;
    i_cmd_op    = op;
    for (int k = 0; k < 100 && !done; k++) begin
      if (o_cmd_ready) done = 1'b1;
      step();
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 200 && rsp_q.size() < n; k++) step();
    if (rsp_q.size() < n) check("rsp_timeout", 32'(rsp_q.size()), 32'(n));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && o_busy; k++) step();
    check("idle", 32'(o_busy), 32'd0);
  endtask

  task automatic check_rsp(input string tag, input int idx, input logic [7:0] data,
                           input logic [3:0] op, input logic divz);
    logic [12:0] r;
    r = (idx < rsp_q.size()) ? rsp_q[idx] : 13'h1FFF;
    check({tag, "_data"}, 32'(r[12:5]), 32'(data));
    check({tag, "_op"},   32'(r[4:1]),  32'(op));
    check({tag, "_divz"}, 32'(r[0]),    32'(divz));
  endtask

  task automatic clear_q();
    rsp_q.delete();
    stamp_q.delete();
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [7:0] data;
  } vec_t;

  vec_t bp_vec[6];
  vec_t st_vec[8];

  initial begin
    bp_vec[0] = '{4'd1,  4'd2,  4'd0,  8'd3};
    bp_vec[1] = '{4'd7,  4'd3,  4'd1,  8'd4};
    bp_vec[2] = '{4'd2,  4'd5,  4'd2,  8'd10};
    bp_vec[3] = '{4'd9,  4'd3,  4'd3,  8'd3};
    bp_vec[4] = '{4'd6,  4'd3,  4'd6,  8'd5};
    bp_vec[5] = '{4'd4,  4'd4,  4'd15, 8'd1};

    st_vec[0] = '{4'd15, 4'd15, 4'd2,  8'd225};
    st_vec[1] = '{4'd3,  4'd5,  4'd1,  8'hFE};
    st_vec[2] = '{4'd6,  4'd6,  4'd15, 8'd1};
    st_vec[3] = '{4'd15, 4'd15, 4'd0,  8'd30};
    st_vec[4] = '{4'd12, 4'd10, 4'd4,  8'd8};
    st_vec[5] = '{4'd12, 4'd10, 4'd6,  8'd6};
    st_vec[6] = '{4'd5,  4'd10, 4'd5,  8'd15};
    st_vec[7] = '{4'd14, 4'd3,  4'd3,  8'd4};

    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_a     = '0;
    i_cmd_b     = '0;
    i_cmd_op    = '0;
    i_rsp_ready = 1'b1;
    repeat (3) step();

    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_busy",      32'(o_busy),      32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_alu",       32'({o_alu_in1, o_alu_in2, o_alu_op}), 32'd0);
    check("rst_rsp",       32'({o_rsp_data, o_rsp_op, o_rsp_divz}), 32'd0);
    i_rst = 1'b0;
    step();

    // Single add: valid rises after the second edge following acceptance.
    clear_q();
    send(4'd9, 4'd7, 4'd0);
    check("single_busy", 32'(o_busy), 32'd1);
    step();
    check("single_valid_n1", 32'(o_rsp_valid), 32'd0);
    check("single_alu_in1",  32'(o_alu_in1),   32'd9);
    step();
    check("single_valid_n2", 32'(o_rsp_valid), 32'd1);
    check("single_data",     32'(o_rsp_data),  32'd16);
    check("single_divz",     32'(o_rsp_divz),  32'd0);
    wait_rsp(1);
    check_rsp("single", 0, 8'd16, 4'd0, 1'b0);
    wait_idle();

    // Divide by zero, then an ordinary divide.
    clear_q();
    send(4'd5, 4'd0, 4'd3);
    send(4'd8, 4'd2, 4'd3);
    wait_rsp(2);
    check_rsp("divz", 0, 8'hFF, 4'd3, 1'b1);
    check_rsp("div",  1, 8'd4,  4'd3, 1'b0);
    wait_idle();

    // Backpressure: the head is already popped into the ALU stage, so the
    // four-entry queue is full only after the fifth acceptance.
    clear_q();
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(bp_vec[i].a, bp_vec[i].b, bp_vec[i].op);
    check("bp_ready_low", 32'(o_cmd_ready), 32'd0);
    i_cmd_valid = 1'b1;
    i_cmd_a     = bp_vec[5].a;
    i_cmd_b     = bp_vec[5].b;
    i_cmd_op    = bp_vec[5].op;
    repeat (3) step();
    check("bp_held_ready", 32'(o_cmd_ready), 32'd0);
    check("bp_held_data",  32'(o_rsp_data),  32'd3);
    check("bp_no_rsp",     32'(rsp_q.size()), 32'd0);
    i_rsp_ready = 1'b1;
    send(bp_vec[5].a, bp_vec[5].b, bp_vec[5].op);
    wait_rsp(6);
    for (int i = 0; i < 6; i++)
      check_rsp($sformatf("bp%0d", i), i, bp_vec[i].data, bp_vec[i].op, 1'b0);
    wait_idle();

    // Streaming: results every two cycles, in order, across pointer wrap.
    clear_q();
    for (int i = 0; i < 8; i++) send(st_vec[i].a, st_vec[i].b, st_vec[i].op);
    wait_rsp(8);
    for (int i = 0; i < 8; i++)
      check_rsp($sformatf("st%0d", i), i, st_vec[i].data, st_vec[i].op, 1'b0);
    for (int i = 1; i < 8 && i < stamp_q.size(); i++)
      check($sformatf("st_gap%0d", i), 32'(stamp_q[i] - stamp_q[i-1]), 32'd2);
    wait_idle();

    // Reset while holding a response with three commands queued.
    clear_q();
    i_rsp_ready = 1'b0;
    send(4'd5, 4'd0, 4'd3);
    send(4'd1, 4'd1, 4'd0);
    send(4'd2, 4'd2, 4'd0);
    send(4'd3, 4'd3, 4'd0);
    check("pre_rst_valid", 32'(o_rsp_valid), 32'd1);
    check("pre_rst_divz",  32'(o_rsp_divz),  32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
    check("mid_rst_divz",  32'(o_rsp_divz),  32'd0);
    check("mid_rst_busy",  32'(o_busy),      32'd0);
    check("mid_rst_ready", 32'(o_cmd_ready), 32'd1);
    check("mid_rst_alu",   32'({o_alu_in1, o_alu_in2, o_alu_op}), 32'd0);
    check("mid_rst_rsp",   32'({o_rsp_data, o_rsp_op}), 32'd0);
    repeat (2) step();
    i_rst = 1'b0;
    clear_q();
    i_rsp_ready = 1'b1;
    repeat (10) step();
    check("post_rst_no_rsp", 32'(rsp_q.size()), 32'd0);
    check("post_rst_busy",   32'(o_busy),       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
